sm4_round_engine: RTL and testbench
===================================

SM4_ROUND_ENGINE -- requirements
Module: sm4_round_engine

Interface
REQ-001 SHALL have parameter UNROLL, default 1: SM4 rounds computed per clock; legal values 1, 2, 4, 8, 16, 32; any other value SHALL fail elaboration.
REQ-002 SHALL have port i_clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  input block valid.
REQ-005 SHALL have port o_ready  output  1  engine can accept a block.
REQ-006 SHALL have port i_mode  input  1  0 = encrypt, 1 = decrypt.
REQ-007 SHALL have port i_data  input  128  input block; X0 is in [127:96].
REQ-008 SHALL have port i_rk_all  input  1024  round keys; rk0 is in [1023:992], rk31 is in [31:0].
REQ-009 SHALL have port o_valid  output  1  result valid.
REQ-010 SHALL have port i_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port o_data  output  128  result block.
REQ-012 SHALL have port o_busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL hold o_ready = 1 only in IDLE.
REQ-015 SHALL accept a block on any edge where i_valid && o_ready; at acceptance, latch i_data, i_mode and i_rk_all; clear round counter rc; go to RUN.
REQ-016 SHALL, on each RUN cycle, apply UNROLL consecutive rounds combinationally and advance rc by UNROLL; rc width SHALL be 6 bits.
REQ-017 SHALL compute each round as X(i+4) = X(i) ^ T(X(i+1)^X(i+2)^X(i+3)^rk), where T = L(tau(.)).
REQ-018 SHALL define tau as the standard SM4 8-bit S-box applied to all four bytes, implemented as a combinational table.
REQ-019 SHALL define L(B) = B ^ (B<<<2) ^ (B<<<10) ^ (B<<<18) ^ (B<<<24).
REQ-020 SHALL use rk[rc+j] for the j-th round of a cycle in encrypt mode and rk[31-(rc+j)] in decrypt mode.
REQ-021 SHALL leave RUN for DONE on the edge that completes round 31, i.e. the (32/UNROLL)-th RUN edge.
REQ-022 SHALL, on that same edge, register o_data = {X35, X34, X33, X32} (reverse transform R) and set o_valid = 1.
REQ-023 SHALL make latency from the accepting edge to o_valid high equal to 32/UNROLL edges: 32 for UNROLL=1, 1 for UNROLL=32.
REQ-024 SHALL, in DONE, hold o_valid and o_data stable until i_ready = 1; on the edge with o_valid && i_ready, clear o_valid and go to IDLE.
REQ-025 SHALL accept the next block no earlier than the edge after the IDLE return; minimum block-to-block spacing = 32/UNROLL + 2 cycles.
REQ-026 SHALL ignore i_valid, i_mode, i_data and i_rk_all changes while in RUN or DONE.
REQ-027 SHALL leave o_data at its last value after the handshake; o_data is don't-care when o_valid = 0, but SHALL NOT change until the next DONE entry.
REQ-028 SHALL ignore i_ready while o_valid = 0.

Reset
REQ-029 SHALL, on i_rst, immediately force: state = IDLE, rc = 0, o_valid = 0, o_data = 0, all latched data/keys = 0; o_ready = 1, o_busy = 0.
REQ-030 SHALL, on reset mid-RUN or mid-DONE, discard the in-flight block and produce no o_valid after reset release.
REQ-031 SHALL not accept a block on the first edge while i_rst is high; acceptance is possible from the first edge after deassertion.

Verification
REQ-032 SHALL pass the standard vector: key 0123456789abcdeffedcba9876543210 (rk0 = f12186f9, rk31 = 9124a012 from the bench model), encrypt plaintext 0123456789abcdeffedcba9876543210 -> o_data = 681edf34d206965e86b3e94f536e4246, o_valid exactly 32/UNROLL edges after accept; run for UNROLL = 1, 4, 32.
REQ-033 SHALL pass decrypt: same keys, mode 1, input 681edf34d206965e86b3e94f536e4246 -> o_data = 0123456789abcdeffedcba9876543210.
REQ-034 SHALL pass backpressure: i_ready held 0 for 10 cycles after o_valid -> o_valid/o_data stable; i_valid pulsed during DONE is not accepted (o_ready = 0).
REQ-035 SHALL pass input corruption: change i_data, i_rk_all and i_mode every cycle during RUN -> result unchanged from the REQ-032 value.
REQ-036 SHALL pass reset mid-operation: assert i_rst at RUN cycle 5 -> o_valid = 0, o_data = 0, o_ready = 1 immediately; no spurious o_valid over the next 40 cycles.
REQ-037 SHALL pass back-to-back: 1000 random blocks, keys and modes with random i_valid/i_ready -> every result matches the bench model, in order, with none lost or duplicated.

Source files
------------

// File: rtl/sm4_round_engine.sv
// sm4_round_engine -- iterative SM4 block cipher core.
// Takes one 128-bit block and its 32 precomputed round keys. It runs the 32
// SM4 rounds, UNROLL rounds per clock, then holds the result until the
// downstream side takes it.
// Ports:
//   i_clk, i_rst       clock; asynchronous active-high reset
//   i_valid, o_ready   input handshake (o_ready is high only in IDLE)
//   i_mode             0 = encrypt, 1 = decrypt (round keys used in reverse order)
//   i_data             input block, X0 in [127:96]
//   i_rk_all           round keys, rk0 in [1023:992] ... rk31 in [31:0]
//   o_valid, i_ready   output handshake
//   o_data             result block {X35, X34, X33, X32}
//   o_busy             high while a block is in flight (RUN or DONE)

module sm4_round_engine #(
   parameter int unsigned UNROLL = 1
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_valid,
   output logic           o_ready,
   input  logic           i_mode,
   input  logic [127:0]   i_data,
   input  logic [1023:0]  i_rk_all,
   output logic           o_valid,
   input  logic           i_ready,
   output logic [127:0]   o_data,
   output logic           o_busy
);

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 ||
         UNROLL == 16 || UNROLL == 32)) begin : g_bad_unroll
      $fatal(1, "sm4_round_engine: UNROLL must be 1, 2, 4, 8, 16 or 32");
   end

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   localparam logic [5:0] RC_STEP = 6'(UNROLL);
   localparam logic [5:0] RC_LAST = 6'(32 - UNROLL);   // rc value at the start of the final RUN cycle

   localparam logic [7:0] SBOX [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   // T = L(tau(a)); L is the sum of rotate-lefts by 0, 2, 10, 18 and 24.
   function automatic logic [31:0] t_xform(input logic [31:0] a);
      logic [31:0] b;
      b = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
      return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^
             {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
   endfunction

   state_t         state_q, state_d;
   logic [5:0]     rc_q, rc_d;
   logic           mode_q, mode_d;
   logic [127:0]   x_q, x_d;         // sliding window {X(i), X(i+1), X(i+2), X(i+3)}
   logic [1023:0]  rk_q, rk_d;
   logic [127:0]   out_q, out_d;
   logic [127:0]   x_rounds;         // window after this cycle's UNROLL rounds
   logic           last_run;

   assign last_run = (rc_q == RC_LAST);

   // UNROLL chained rounds in one cycle.
   always_comb begin
      logic [127:0] x;
      logic [4:0]   k;
      logic [31:0]  rk;
      // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
      x  = x_q;
      k  = '0;
      rk = '0;
      for (int j = 0; j < int'(UNROLL); j++) begin
         k = rc_q[4:0] + 5'(j);
         if (mode_q) begin
            k = ~k;                          // decrypt walks the keys backwards: 31 - (rc + j)
         end
         rk = rk_q[{~k, 5'b0} +: 32];        // rk[k] starts at bit (31 - k) * 32
         x  = {x[95:0], x[127:96] ^ t_xform(x[95:64] ^ x[63:32] ^ x[31:0] ^ rk)};
      end
      x_rounds = x;
   end

   // FSM: state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
      end else begin
         // NOTE: sequential state is always updated with non-blocking assignments.
         state_q <= state_d;
      end
   end

   // FSM: next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (i_valid)  state_d = S_RUN;
         S_RUN:   if (last_run) state_d = S_DONE;
         S_DONE:  if (i_ready)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs.
   always_comb begin
      o_ready = (state_q == S_IDLE);
      o_busy  = (state_q != S_IDLE);
      o_valid = (state_q == S_DONE);
   end

   assign o_data = out_q;

   // Datapath next state. Inputs are only looked at in IDLE, so changes
   // during RUN and DONE have no effect.
   always_comb begin
      rc_d   = rc_q;
      mode_d = mode_q;
      x_d    = x_q;
      rk_d   = rk_q;
      out_d  = out_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               rc_d   = '0;
               mode_d = i_mode;
               x_d    = i_data;
               rk_d   = i_rk_all;
            end
         end
         S_RUN: begin
            x_d  = x_rounds;
            rc_d = rc_q + RC_STEP;
            if (last_run) begin
               // Reverse transform R: {X35, X34, X33, X32}.
               out_d = {x_rounds[31:0], x_rounds[63:32], x_rounds[95:64], x_rounds[127:96]};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         // NOTE: the wide key and data registers are reset too, so no trace of a
         // previous block's keys or data survives a reset.
         rc_q   <= '0;
         mode_q <= 1'b0;
         x_q    <= '0;
         rk_q   <= '0;
         out_q  <= '0;
      end else begin
         rc_q   <= rc_d;
         mode_q <= mode_d;
         x_q    <= x_d;
         rk_q   <= rk_d;
         out_q  <= out_d;
      end
   end

endmodule

// File: tb/tb_sm4_round_engine.sv
// tb_sm4_round_engine -- self-checking bench for sm4_round_engine.
// The main instance uses UNROLL = 4. Two extra instances (UNROLL = 1 and 32)
// share its inputs and are checked on the standard vectors only. A reference
// model computes SM4 round by round (key schedule included). A negedge
// monitor scores every accepted block of the main instance, in order.

module tb_sm4_round_engine;

   localparam int unsigned U_MAIN   = 4;
   localparam int unsigned LAT_MAIN = 32 / U_MAIN;
   localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;

   logic           i_clk = 1'b0;
   logic           i_rst = 1'b1;
   logic           i_valid = 1'b0;
   logic           i_mode = 1'b0;
   logic           i_ready = 1'b0;
   logic [127:0]   i_data = '0;
   logic [1023:0]  i_rk_all = '0;
   logic           o_ready, o_valid, o_busy;
   logic [127:0]   o_data;
   logic           a1_ready, a1_valid, a1_busy;
   logic [127:0]   a1_data;
   logic           a32_ready, a32_valid, a32_busy;
   logic [127:0]   a32_data;

   sm4_round_engine #(.UNROLL(U_MAIN)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_mode(i_mode), .i_data(i_data), .i_rk_all(i_rk_all), .o_valid(o_valid),
      .i_ready(i_ready), .o_data(o_data), .o_busy(o_busy));

   sm4_round_engine #(.UNROLL(1)) dut_u1 (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(a1_ready),
      .i_mode(i_mode), .i_data(i_data), .i_rk_all(i_rk_all), .o_valid(a1_valid),
      .i_ready(i_ready), .o_data(a1_data), .o_busy(a1_busy));

   sm4_round_engine #(.UNROLL(32)) dut_u32 (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(a32_ready),
      .i_mode(i_mode), .i_data(i_data), .i_rk_all(i_rk_all), .o_valid(a32_valid),
      .i_ready(i_ready), .o_data(a32_data), .o_busy(a32_busy));

   always #5 i_clk = ~i_clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   localparam logic [7:0] SBOX [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   function automatic logic [31:0] rol(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [31:0] tau(input logic [31:0] a);
      return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
   endfunction

   function automatic logic [31:0] rk_word(input logic [1023:0] all, input int i);
      logic [1023:0] s;
      s = all >> (32 * (31 - i));
      return s[31:0];
   endfunction

   // Standard SM4 key schedule; rk0 lands in the top word.
   function automatic logic [1023:0] expand(input logic [127:0] mk);
      logic [31:0]   fk [4];
      logic [31:0]   k [36];
      logic [31:0]   ck, b;
      logic [1023:0] r;
      fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350; fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
      for (int i = 0; i < 4; i++) k[i] = 32'(mk >> (32 * (3 - i))) ^ fk[i];
      r = '0;
      for (int i = 0; i < 32; i++) begin
         ck = {8'((4 * i) * 7), 8'((4 * i + 1) * 7), 8'((4 * i + 2) * 7), 8'((4 * i + 3) * 7)};
         b = tau(k[i + 1] ^ k[i + 2] ^ k[i + 3] ^ ck);
         k[i + 4] = k[i] ^ b ^ rol(b, 13) ^ rol(b, 23);
         r = {r[991:0], k[i + 4]};
      end
      return r;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d, input logic [1023:0] rks, input logic mode);
      logic [31:0] x [36];
      logic [31:0] b, rk;
      for (int i = 0; i < 4; i++) x[i] = 32'(d >> (32 * (3 - i)));
      for (int i = 0; i < 32; i++) begin
         rk = mode ? rk_word(rks, 31 - i) : rk_word(rks, i);
         b = tau(x[i + 1] ^ x[i + 2] ^ x[i + 3] ^ rk);
         x[i + 4] = x[i] ^ b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
      end
      return {x[35], x[34], x[33], x[32]};
   endfunction

   // ---------------- scoreboard / compare process (main instance) ----------------
   typedef struct {
      logic [127:0] exp;
      int           acc_edge;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_acc = 0;
   int   n_done = 0;
   int   lat_done_for = -1;

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (i_rst) begin
         sb.delete();
         lat_done_for <= -1;
      end else begin
         check("busy_vs_ready", o_busy, !o_ready);
         if (o_valid) begin
            if (sb.size() == 0) begin
               check("spurious_o_valid", o_valid, 1'b0);
            end else begin
               if (lat_done_for != n_done) begin
                  check("latency", cyc - sb[0].acc_edge, LAT_MAIN);
                  lat_done_for <= n_done;
               end
               check("o_data", o_data, sb[0].exp);
               if (i_ready) begin
                  void'(sb.pop_front());
                  n_done <= n_done + 1;
               end
            end
         end
         if (i_valid && o_ready) begin
            sb.push_back('{model(i_data, i_rk_all, i_mode), cyc + 1});
            n_acc <= n_acc + 1;
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [1023:0] std_rk;

   // Called at posedge+1 with all instances idle; leaves them idle again.
   task automatic run_std(input string tag, input logic [127:0] din, input logic mode, input logic [127:0] exp);
      int lat_m, lat_1, lat_32;
      logic [127:0] d_m, d_1, d_32;
      lat_m = 0; lat_1 = 0; lat_32 = 0;
      d_m = '0; d_1 = '0; d_32 = '0;
      i_data = din; i_mode = mode; i_rk_all = std_rk; i_valid = 1'b1; i_ready = 1'b1;
      check({tag, "_ready_all"}, {o_ready, a1_ready, a32_ready}, 3'b111);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge i_clk); #1;
         if (o_valid && lat_m == 0)    begin lat_m = k;  d_m = o_data;    end
         if (a1_valid && lat_1 == 0)   begin lat_1 = k;  d_1 = a1_data;   end
         if (a32_valid && lat_32 == 0) begin lat_32 = k; d_32 = a32_data; end
      end
      check({tag, "_lat_u4"}, lat_m, 8);
      check({tag, "_lat_u1"}, lat_1, 32);
      check({tag, "_lat_u32"}, lat_32, 1);
      check({tag, "_data_u4"}, d_m, exp);
      check({tag, "_data_u1"}, d_1, exp);
      check({tag, "_data_u32"}, d_32, exp);
   endtask

   task automatic wait_valid(input string tag);
      for (int k = 0; k < 40; k++) begin
         if (o_valid) break;
         @(posedge i_clk); #1;
      end
      check({tag, "_o_valid_rise"}, o_valid, 1'b1);
   endtask

   initial begin
      logic [127:0] hold;
      int start_acc, start_done;

      // Pin the model itself against published values.
      std_rk = expand(PT);
      check("model_rk0", std_rk[1023:992], 32'hf12186f9);
      check("model_rk31", std_rk[31:0], 32'h9124a012);
      check("model_enc", model(PT, std_rk, 1'b0), CT);
      check("model_dec", model(CT, std_rk, 1'b1), PT);

      // Reset state.
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_o_ready", o_ready, 1'b1);
      check("rst_o_busy", o_busy, 1'b0);
      check("rst_o_valid", o_valid, 1'b0);
      check("rst_o_data", o_data, 128'h0);

      // A block offered across an edge while reset is high is not taken.
      i_valid = 1'b1; i_data = PT; i_rk_all = std_rk; i_mode = 1'b0;
      @(posedge i_clk); #1;
      check("rst_no_accept_ready", o_ready, 1'b1);
      check("rst_no_accept_busy", {o_busy, a1_busy, a32_busy}, 3'b000);
      i_rst = 1'b0;

      // Standard vectors on all three unroll factors; first one is taken on
      // the first edge after reset release.
      run_std("std_enc", PT, 1'b0, CT);
      run_std("std_dec", CT, 1'b1, PT);

      // Backpressure: result held for 10 cycles; i_valid during DONE ignored.
      i_ready = 1'b0; i_data = PT; i_mode = 1'b0; i_rk_all = std_rk; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      wait_valid("bp");
      hold = o_data;
      check("bp_first_data", o_data, CT);
      for (int k = 0; k < 10; k++) begin
         i_valid = 1'b1; i_data = ~PT; i_mode = 1'b1;
         @(posedge i_clk); #1;
         check("bp_valid_held", o_valid, 1'b1);
         check("bp_data_held", o_data, hold);
         check("bp_not_ready", o_ready, 1'b0);
      end
      i_valid = 1'b0; i_ready = 1'b1;
      @(posedge i_clk); #1;
      check("bp_valid_cleared", o_valid, 1'b0);
      check("bp_back_to_idle", o_ready, 1'b1);
      check("bp_data_kept", o_data, hold);
      // Let the slow side instance drain so it does not linger in DONE.
      repeat (40) @(posedge i_clk);
      #1;

      // Input corruption during RUN has no effect.
      i_ready = 1'b1; i_data = PT; i_mode = 1'b0; i_rk_all = std_rk; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (o_valid) break;
         i_data = {$urandom, $urandom, $urandom, $urandom};
         for (int w = 0; w < 32; w++) i_rk_all = {i_rk_all[991:0], 32'($urandom)};
         i_mode = ~i_mode;
         @(posedge i_clk); #1;
      end
      check("corrupt_o_valid", o_valid, 1'b1);
      check("corrupt_o_data", o_data, CT);
      @(posedge i_clk); #1;
      repeat (40) @(posedge i_clk);
      #1;

      // Reset in the middle of RUN.
      i_ready = 1'b1; i_data = PT; i_mode = 1'b0; i_rk_all = std_rk; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      repeat (5) @(posedge i_clk);
      #2;
      check("midrst_busy_before", o_busy, 1'b1);
      i_rst = 1'b1;
      #1;
      check("midrst_o_valid", o_valid, 1'b0);
      check("midrst_o_data", o_data, 128'h0);
      check("midrst_o_ready", o_ready, 1'b1);
      check("midrst_o_busy", o_busy, 1'b0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge i_clk); #1;
         check("midrst_no_valid", {o_valid, a1_valid, a32_valid}, 3'b000);
      end

      // 1000 random blocks with random handshakes.
      start_acc = n_acc;
      start_done = n_done;
      for (int t = 0; t < 60000; t++) begin
         if (n_acc - start_acc >= 1000) i_valid = 1'b0;
         else                           i_valid = 1'($urandom_range(0, 1));
         i_ready = ($urandom_range(0, 3) != 0);
         i_mode = 1'($urandom_range(0, 1));
         i_data = {$urandom, $urandom, $urandom, $urandom};
         for (int w = 0; w < 32; w++) i_rk_all = {i_rk_all[991:0], 32'($urandom)};
         @(posedge i_clk); #1;
         if (n_acc - start_acc >= 1000 && sb.size() == 0 && !o_valid) break;
      end
      check("rand_accepted", n_acc - start_acc, 1000);
      check("rand_completed", n_done - start_done, 1000);
      check("rand_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
